// File: rtl/alu_unit_pkg.sv
// Shared types for the alu_unit slice: operation encoding and a name helper for display.
package alu_unit_pkg;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_XOR = 2'b01,
    ALU_ADD = 2'b10,
    ALU_MUL = 2'b11
  } alu_op_e;

  function automatic string op_name(input alu_op_e op);
    case (op)
      ALU_AND: return "AND";
      ALU_XOR: return "XOR";
      ALU_ADD: return "ADD";
      ALU_MUL: return "MUL";
      default: return "UNK";
    endcase
  endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Operand/result bus of alu_unit. With ALU_UNIT_FLAGS_EN defined it also carries zero/carry.
interface alu_unit_if #(parameter int W = 2);
  import alu_unit_pkg::*;

  logic             in_valid;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  alu_op_e          op;
  logic [2*W-1:0]   result;
  logic             out_valid;

`ifdef ALU_UNIT_FLAGS_EN
  logic             zero;
  logic             carry;

  modport master (output in_valid, a, b, op, input result, out_valid, zero, carry);
  modport slave  (input in_valid, a, b, op, output result, out_valid, zero, carry);
`else
  modport master (output in_valid, a, b, op, input result, out_valid);
  modport slave  (input in_valid, a, b, op, output result, out_valid);
`endif

endinterface

// File: rtl/alu_unit_mul.sv
// Unsigned W x W -> 2W combinational shift-add multiplier; the product is never truncated.
module alu_unit_mul #(
  parameter int W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product
);

  localparam int RES_W = 2 * W;

  logic [RES_W-1:0] a_ext_s;

  assign a_ext_s = RES_W'(a);

  // Accumulate one shifted partial product per set bit of b.
  always_comb begin
    product = {RES_W{1'b0}};
    for (int i = 0; i < W; i++) begin
      if (b[i]) begin
        product = product + (a_ext_s << i);
      end else begin
        product = product;
      end
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Registered AND/XOR/ADD/MUL unit, one-cycle latency, 2W-bit zero-extended result.
// Optional zero/carry outputs are built when ALU_UNIT_FLAGS_EN is defined.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int W = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_unit_if.slave bus
);

  localparam int RES_W = 2 * W;

  logic [W:0]       sum_s;
  logic [RES_W-1:0] product_s;
  logic [RES_W-1:0] result_s;
  logic [RES_W-1:0] result_r;
  logic             out_valid_r;
`ifdef ALU_UNIT_FLAGS_EN
  logic             zero_s;
  logic             carry_s;
  logic             zero_r;
  logic             carry_r;
`endif

  alu_unit_mul #(.W(W)) u_mul (
    .a       (bus.a),
    .b       (bus.b),
    .product (product_s)
  );

  // Operation mux; an unknown op falls to the default and yields zero.
  always_comb begin
    sum_s = {1'b0, bus.a} + {1'b0, bus.b};
    case (bus.op)
      ALU_AND: result_s = RES_W'(bus.a & bus.b);
      ALU_XOR: result_s = RES_W'(bus.a ^ bus.b);
      ALU_ADD: result_s = RES_W'(sum_s);
      ALU_MUL: result_s = product_s;
      default: result_s = {RES_W{1'b0}};
    endcase
`ifdef ALU_UNIT_FLAGS_EN
    zero_s = (result_s == {RES_W{1'b0}});
    if (bus.op == ALU_ADD) begin
      carry_s = sum_s[W];
    end else begin
      carry_s = 1'b0;
    end
`endif
  end

  // Output register: load on in_valid, otherwise hold result and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= {RES_W{1'b0}};
      out_valid_r <= 1'b0;
`ifdef ALU_UNIT_FLAGS_EN
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
`endif
    end else if (bus.in_valid) begin
      result_r    <= result_s;
      out_valid_r <= 1'b1;
`ifdef ALU_UNIT_FLAGS_EN
      zero_r      <= zero_s;
      carry_r     <= carry_s;
`endif
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.result    = result_r;
  assign bus.out_valid = out_valid_r;
`ifdef ALU_UNIT_FLAGS_EN
  assign bus.zero      = zero_r;
  assign bus.carry     = carry_r;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Directed and model-based bench for alu_unit at W=2 and W=4; flag checks when ALU_UNIT_FLAGS_EN is defined.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_unit_if #(.W(2)) bus2 ();
  alu_unit_if #(.W(4)) bus4 ();

  alu_unit #(.W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  alu_unit #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input alu_op_e op);
    logic [7:0] ae;
    logic [7:0] be;
    ae = {4'd0, a};
    be = {4'd0, b};
    case (op)
      ALU_AND: return ae & be;
      ALU_XOR: return ae ^ be;
      ALU_ADD: return ae + be;
      ALU_MUL: return ae * be;
      default: return 8'd0;
    endcase
  endfunction

  task automatic drive2(input logic v, input logic [1:0] a, input logic [1:0] b, input alu_op_e op);
    bus2.in_valid = v;
    bus2.a        = a;
    bus2.b        = b;
    bus2.op       = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus2.in_valid = 1'b1;
    bus2.a  = 2'($urandom);
    bus2.b  = 2'($urandom);
    bus2.op = alu_op_e'(2'($urandom));
    bus4.in_valid = 1'b1;
    bus4.a  = 4'($urandom);
    bus4.b  = 4'($urandom);
    bus4.op = alu_op_e'(2'($urandom));
    repeat (3) step();
    checks++;
    if (bus2.result !== 4'd0 || bus2.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_w2: got result=%0d valid=%0b expected 0/0", bus2.result, bus2.out_valid);
    end
    checks++;
    if (bus4.result !== 8'd0 || bus4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_w4: got result=%0d valid=%0b expected 0/0", bus4.result, bus4.out_valid);
    end
    drive2(1'b0, 2'd1, 2'd2, ALU_ADD);
    bus4.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      step();
      checks++;
      if (bus2.result !== 4'd0 || bus2.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle: got result=%0d valid=%0b expected 0/0", bus2.result, bus2.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_sweep [4];
    exp_sweep = '{4'd2, 4'd1, 4'd5, 4'd6};
    for (int i = 0; i < 4; i++) begin
      drive2(1'b1, 2'd2, 2'd3, alu_op_e'(2'(i)));
      step();
      checks++;
      if (bus2.result !== exp_sweep[i] || bus2.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL sweep_%s: got result=%0d valid=%0b expected %0d/1",
                 op_name(alu_op_e'(2'(i))), bus2.result, bus2.out_valid, exp_sweep[i]);
      end
    end
  endtask

  task automatic test_corners();
    logic [3:0] exp_max [4];
    exp_max = '{4'd3, 4'd0, 4'd6, 4'd9};
    for (int i = 0; i < 4; i++) begin
      drive2(1'b1, 2'd3, 2'd3, alu_op_e'(2'(i)));
      step();
      checks++;
      if (bus2.result !== exp_max[i] || bus2.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL max_%s: got result=%0d valid=%0b expected %0d/1",
                 op_name(alu_op_e'(2'(i))), bus2.result, bus2.out_valid, exp_max[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive2(1'b1, 2'd0, 2'd0, alu_op_e'(2'(i)));
      step();
      checks++;
      if (bus2.result !== 4'd0 || bus2.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL zero_operands_%s: got result=%0d valid=%0b expected 0/1",
                 op_name(alu_op_e'(2'(i))), bus2.result, bus2.out_valid);
      end
`ifdef ALU_UNIT_FLAGS_EN
      checks++;
      if (bus2.zero !== 1'b1 || bus2.carry !== 1'b0) begin
        failures++;
        $display("FAIL zero_flag_%s: got zero=%0b carry=%0b expected 1/0",
                 op_name(alu_op_e'(2'(i))), bus2.zero, bus2.carry);
      end
`endif
    end
  endtask

  task automatic test_hold();
    drive2(1'b1, 2'd1, 2'd1, ALU_ADD);
    step();
    checks++;
    if (bus2.result !== 4'd2 || bus2.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL hold_load: got result=%0d valid=%0b expected 2/1", bus2.result, bus2.out_valid);
    end
    drive2(1'b0, 2'd3, 2'd2, ALU_MUL);
    repeat (2) begin
      step();
      checks++;
      if (bus2.result !== 4'd2 || bus2.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL hold_idle: got result=%0d valid=%0b expected 2/0", bus2.result, bus2.out_valid);
      end
    end
  endtask

  task automatic test_unknown_op();
    bus2.in_valid = 1'b1;
    bus2.a  = 2'd2;
    bus2.b  = 2'd1;
    bus2.op = alu_op_e'(2'bxx);
    step();
    checks++;
    if (bus2.result !== 4'd0 || bus2.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL unknown_op: got result=%0d valid=%0b expected 0/1", bus2.result, bus2.out_valid);
    end
  endtask

  task automatic test_async_reset();
    drive2(1'b1, 2'd3, 2'd3, ALU_MUL);
    step();
    checks++;
    if (bus2.result !== 4'd9 || bus2.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL async_pre: got result=%0d valid=%0b expected 9/1", bus2.result, bus2.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus2.result !== 4'd0 || bus2.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_clear: got result=%0d valid=%0b expected 0/0", bus2.result, bus2.out_valid);
    end
    #1;
    rst_n = 1'b1;
    step();
    checks++;
    if (bus2.result !== 4'd9 || bus2.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL async_recover: got result=%0d valid=%0b expected 9/1", bus2.result, bus2.out_valid);
    end
  endtask

  task automatic test_flags();
`ifdef ALU_UNIT_FLAGS_EN
    drive2(1'b1, 2'd3, 2'd2, ALU_ADD);
    step();
    checks++;
    if (bus2.result !== 4'd5 || bus2.carry !== 1'b1 || bus2.zero !== 1'b0) begin
      failures++;
      $display("FAIL flags_add_carry: got result=%0d carry=%0b zero=%0b expected 5/1/0",
               bus2.result, bus2.carry, bus2.zero);
    end
    drive2(1'b1, 2'd3, 2'd3, ALU_MUL);
    step();
    checks++;
    if (bus2.result !== 4'd9 || bus2.carry !== 1'b0) begin
      failures++;
      $display("FAIL flags_mul_nocarry: got result=%0d carry=%0b expected 9/0", bus2.result, bus2.carry);
    end
    drive2(1'b0, 2'd0, 2'd0, ALU_AND);
    step();
    checks++;
    if (bus2.carry !== 1'b0 || bus2.zero !== 1'b0 || bus2.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flags_hold: got carry=%0b zero=%0b valid=%0b expected 0/0/0",
               bus2.carry, bus2.zero, bus2.out_valid);
    end
`endif
  endtask

  task automatic test_exhaustive_w2();
    logic [7:0] exp;
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int io = 0; io < 4; io++) begin
          drive2(1'b1, 2'(ia), 2'(ib), alu_op_e'(2'(io)));
          exp = ref_alu(4'(ia), 4'(ib), alu_op_e'(2'(io)));
          step();
          checks++;
          if ({4'd0, bus2.result} !== exp || bus2.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL exh_w2 a=%0d b=%0d op=%s: got %0d valid=%0b expected %0d/1",
                     ia, ib, op_name(alu_op_e'(2'(io))), bus2.result, bus2.out_valid, exp);
          end
`ifdef ALU_UNIT_FLAGS_EN
          checks++;
          if (bus2.zero !== (exp == 8'd0) ||
              bus2.carry !== ((io == 2) && (ia + ib >= 4))) begin
            failures++;
            $display("FAIL exh_w2_flags a=%0d b=%0d op=%0d: got zero=%0b carry=%0b",
                     ia, ib, io, bus2.zero, bus2.carry);
          end
`endif
        end
      end
    end
    drive2(1'b0, 2'd0, 2'd0, ALU_AND);
  endtask

  task automatic test_random_w4();
    logic [7:0] exp_r;
    logic       exp_v;
    exp_r = 8'd0;
    for (int n = 0; n < 1200; n++) begin
      bus4.in_valid = (n == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
      bus4.a  = 4'($urandom);
      bus4.b  = 4'($urandom);
      bus4.op = alu_op_e'(2'($urandom));
      if (bus4.in_valid) begin
        exp_r = ref_alu(bus4.a, bus4.b, bus4.op);
        exp_v = 1'b1;
      end else begin
        exp_v = 1'b0;
      end
      step();
      checks++;
      if (bus4.result !== exp_r || bus4.out_valid !== exp_v) begin
        failures++;
        $display("FAIL rand_w4 n=%0d: got result=%0d valid=%0b expected %0d/%0b",
                 n, bus4.result, bus4.out_valid, exp_r, exp_v);
      end
    end
    bus4.in_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_corners();
    test_hold();
    test_unknown_op();
    test_async_reset();
    test_flags();
    test_exhaustive_w2();
    test_random_w4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
